// File: rtl/mag_window_stats_if.sv
// Sample/threshold inputs and registered statistics outputs of the magnitude window-stats stage.
interface mag_window_stats_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_mag;
    logic             clear;
    logic [WIDTH-1:0] th_hi;
    logic [WIDTH-1:0] th_lo;
    logic             out_valid;
    logic [WIDTH-1:0] avg_out;
    logic [WIDTH-1:0] peak_out;
    logic             window_full;
    logic             alarm;
    logic [7:0]       alarm_count;

    modport master (
        output in_valid, in_mag, clear, th_hi, th_lo,
        input  out_valid, avg_out, peak_out, window_full, alarm, alarm_count
    );

    modport slave (
        input  in_valid, in_mag, clear, th_hi, th_lo,
        output out_valid, avg_out, peak_out, window_full, alarm, alarm_count
    );
endinterface

// File: rtl/mag_window_stats.sv
// Two-stage streaming statistics over an 8-sample circular window:
// moving average, peak hold and a hysteresis alarm with saturating rising-edge count.
module mag_window_stats #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned WIN_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    mag_window_stats_if.slave bus
);
    localparam int unsigned DEPTH  = 1 << WIN_LOG2;
    localparam int unsigned SUM_W  = WIDTH + WIN_LOG2;
    localparam int unsigned FILL_W = WIN_LOG2 + 1;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;

    logic [WIDTH-1:0]    win_mem [DEPTH];
    logic [WIN_LOG2-1:0] wr_ptr_q;
    logic [SUM_W-1:0]    sum_q;
    logic [FILL_W-1:0]   fill_q;
    logic                s2_valid_q;
    logic [WIDTH-1:0]    s2_mag_q;

    logic                out_valid_q;
    logic [WIDTH-1:0]    avg_q;
    logic [WIDTH-1:0]    peak_q;
    logic                full_q;

    state_t              state_q, state_d;
    logic                alarm_q, alarm_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                accept;
    logic                full_now;
    logic [WIDTH-1:0]    avg_new;

    assign accept   = bus.in_valid && !bus.clear;
    assign full_now = (fill_q == FILL_W'(DEPTH));
    assign avg_new  = sum_q[SUM_W-1:WIN_LOG2];

    // Stage 1: window write with running-sum update; clear beats a same-cycle sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) win_mem[i] <= '0;
            wr_ptr_q   <= '0;
            sum_q      <= '0;
            fill_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_mag_q   <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < int'(DEPTH); i++) win_mem[i] <= '0;
            wr_ptr_q   <= '0;
            sum_q      <= '0;
            fill_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_mag_q   <= '0;
        end else begin
            s2_valid_q <= accept;
            if (accept) begin
                sum_q             <= sum_q - SUM_W'(win_mem[wr_ptr_q]) + SUM_W'(bus.in_mag);
                win_mem[wr_ptr_q] <= bus.in_mag;
                wr_ptr_q          <= wr_ptr_q + WIN_LOG2'(1);
                s2_mag_q          <= bus.in_mag;
                if (!full_now) fill_q <= fill_q + FILL_W'(1);
            end
        end
    end

    // Stage 2: publish average, peak and fill status for the sample in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            avg_q       <= '0;
            peak_q      <= '0;
            full_q      <= 1'b0;
        end else if (bus.clear) begin
            out_valid_q <= 1'b0;
            avg_q       <= '0;
            peak_q      <= '0;
            full_q      <= 1'b0;
        end else begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                avg_q  <= avg_new;
                full_q <= full_now;
                if (s2_mag_q > peak_q) peak_q <= s2_mag_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            alarm_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
            count_q <= count_d;
        end
    end

    // Alarm evaluation begins on the same update that first sees a full window
    always_comb begin
        state_d = state_q;
        alarm_d = alarm_q;
        count_d = count_q;
        if (bus.clear) begin
            state_d = ST_FILL;
            alarm_d = 1'b0;
            count_d = '0;
        end else if (s2_valid_q && (state_q == ST_RUN || full_now)) begin
            state_d = ST_RUN;
            if (avg_new >= bus.th_hi) begin
                alarm_d = 1'b1;
                if (!alarm_q && count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
            end else if (avg_new < bus.th_lo) begin
                alarm_d = 1'b0;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.avg_out     = avg_q;
    assign bus.peak_out    = peak_q;
    assign bus.window_full = full_q;
    assign bus.alarm       = alarm_q;
    assign bus.alarm_count = count_q;
endmodule

// File: tb/tb_mag_window_stats.sv
// Randomized and directed checking of mag_window_stats against a window-array reference model.
module tb_mag_window_stats;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mag_window_stats_if #(.WIDTH(8)) bus ();

    mag_window_stats #(.WIDTH(8), .WIN_LOG2(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain window array, expected outputs and the sample in flight
    int m_win[8];
    int m_ptr, m_cnt, m_pmag;
    bit m_pend;
    int e_avg, e_peak, e_acnt;
    bit e_full, e_alarm, e_ov;

    bit rec;
    int rec_q[$];

    function automatic int m_avg();
        int s = 0;
        for (int i = 0; i < 8; i++) s += m_win[i];
        return s / 8;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_win[i] = 0;
        m_ptr = 0; m_cnt = 0; m_pmag = 0; m_pend = 0;
        e_avg = 0; e_peak = 0; e_acnt = 0;
        e_full = 0; e_alarm = 0; e_ov = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === 32'(expv)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".out_valid"},   32'(bus.out_valid),   int'(e_ov));
        chk({where, ".avg_out"},     32'(bus.avg_out),     e_avg);
        chk({where, ".peak_out"},    32'(bus.peak_out),    e_peak);
        chk({where, ".window_full"}, 32'(bus.window_full), int'(e_full));
        chk({where, ".alarm"},       32'(bus.alarm),       int'(e_alarm));
        chk({where, ".alarm_count"}, 32'(bus.alarm_count), e_acnt);
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare 1 time unit later
    task automatic tick(input bit v, input int m, input bit c);
        int avg;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_mag   = 8'(m);
        bus.clear    = c;
        @(posedge clk);
        e_ov = m_pend && !c;
        if (c) begin
            model_reset();
        end else begin
            if (m_pend) begin
                avg    = m_avg();
                e_avg  = avg;
                e_full = (m_cnt == 8);
                if (m_pmag > e_peak) e_peak = m_pmag;
                if (m_cnt == 8) begin
                    if (avg >= int'(bus.th_hi)) begin
                        if (!e_alarm && e_acnt < 255) e_acnt++;
                        e_alarm = 1;
                    end else if (avg < int'(bus.th_lo)) begin
                        e_alarm = 0;
                    end
                end
            end
            m_pend = v;
            if (v) begin
                m_win[m_ptr] = m;
                m_ptr  = (m_ptr + 1) % 8;
                m_pmag = m;
                if (m_cnt < 8) m_cnt++;
            end
        end
        #1;
        check_all("cyc");
        if (rec && bus.out_valid)
            rec_q.push_back({7'd0, bus.alarm, bus.window_full, bus.peak_out, bus.avg_out});
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 0;
        bus.clear    = 0;
        rst = 1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int zexp[6];
        int samp[24];
        int q_ref[$];
        int v;
        zexp = '{52, 48, 43, 37, 30, 21};
        rec = 0;
        rst = 1;
        bus.in_valid = 0; bus.in_mag = 0; bus.clear = 0;
        bus.th_hi = 8'd50; bus.th_lo = 8'd30;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset_state");
        rst = 0;

        // Some traffic, then an asynchronous reset with a sample in flight
        for (int i = 0; i < 5; i++) tick(1, int'($urandom_range(0, 255)), 0);
        do_reset();

        // First sample after reset appears two edges later
        tick(1, 40, 0);
        tick(0, 0, 0);
        chk("first.out_valid", 32'(bus.out_valid), 1);
        chk("first.avg", 32'(bus.avg_out), 5);
        chk("first.peak", 32'(bus.peak_out), 40);
        chk("first.full", 32'(bus.window_full), 0);

        // Window fill with 10..80
        tick(0, 0, 1);
        for (int i = 1; i <= 8; i++) tick(1, i * 10, 0);
        tick(0, 0, 0);
        chk("fill.avg", 32'(bus.avg_out), 45);
        chk("fill.peak", 32'(bus.peak_out), 80);
        chk("fill.full", 32'(bus.window_full), 1);
        chk("fill.alarm", 32'(bus.alarm), 0);

        // Wrap sets the alarm
        tick(1, 90, 0);
        tick(0, 0, 0);
        chk("wrap.avg", 32'(bus.avg_out), 55);
        chk("wrap.alarm", 32'(bus.alarm), 1);
        chk("wrap.count", 32'(bus.alarm_count), 1);
        chk("wrap.peak", 32'(bus.peak_out), 90);

        // Hysteresis release
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, 0);
            tick(0, 0, 0);
            chk($sformatf("hyst.avg%0d", i), 32'(bus.avg_out), zexp[i]);
            chk($sformatf("hyst.alarm%0d", i), 32'(bus.alarm), (i < 5) ? 1 : 0);
            chk($sformatf("hyst.count%0d", i), 32'(bus.alarm_count), 1);
        end

        // Clear collides with a sample
        tick(1, 77, 0);
        tick(1, 200, 1);
        chk("clr.out_valid", 32'(bus.out_valid), 0);
        chk("clr.alarm", 32'(bus.alarm), 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0);
            chk("clr.idle_valid", 32'(bus.out_valid), 0);
            chk("clr.idle_peak", 32'(bus.peak_out), 0);
        end

        // Alarm counter saturation
        bus.th_hi = 8'd100; bus.th_lo = 8'd100;
        for (int t = 0; t < 260; t++) begin
            for (int i = 0; i < 8; i++) tick(1, 255, 0);
            for (int i = 0; i < 8; i++) tick(1, 0, 0);
        end
        tick(0, 0, 0);
        chk("sat.count", 32'(bus.alarm_count), 255);

        // Gapped stream must match the gapless one
        bus.th_hi = 8'd120; bus.th_lo = 8'd60;
        for (int i = 0; i < 24; i++) samp[i] = int'($urandom_range(0, 255));
        tick(0, 0, 1);
        rec = 1;
        for (int i = 0; i < 24; i++) tick(1, samp[i], 0);
        tick(0, 0, 0);
        rec = 0;
        q_ref = rec_q;
        rec_q.delete();
        tick(0, 0, 1);
        rec = 1;
        for (int i = 0; i < 24; i++) begin
            tick(1, samp[i], 0);
            repeat ($urandom_range(0, 3)) tick(0, int'($urandom_range(0, 255)), 0);
        end
        tick(0, 0, 0);
        rec = 0;
        chk("gap.count", 32'(rec_q.size()), q_ref.size());
        for (int i = 0; i < q_ref.size() && i < rec_q.size(); i++)
            chk($sformatf("gap.out%0d", i), 32'(rec_q[i]), q_ref[i]);

        // Random traffic with threshold changes, clears and one reset
        for (int i = 0; i < 800; i++) begin
            if (i % 37 == 0) begin
                bus.th_hi = 8'($urandom_range(0, 255));
                bus.th_lo = 8'($urandom_range(0, 255));
            end
            if (i == 400) do_reset();
            v = int'($urandom_range(0, 99));
            tick(v < 70, int'($urandom_range(0, 255)), v == 99);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mag_window_stats.md
# mag_window_stats

Streaming statistics stage placed directly downstream of the magnitude (sqrt(x²+y²)) unit. It accepts one 8-bit magnitude per valid strobe and keeps an 8-sample circular window. From that window it produces a moving average, a peak-hold value, and a hysteresis alarm with a saturating event counter. Results are registered and qualified by a one-cycle out_valid pulse for the I/O or readout logic that follows.

## Interface
- WIDTH, 8, magnitude/average/peak width
- WIN_LOG2, 3, log2 of window depth (window = 8 samples)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_mag valid this cycle; a sample is accepted on every cycle it is high
- in_mag  input  WIDTH  magnitude sample
- clear  input  1  synchronous clear of window, peak, alarm and count
- th_hi  input  WIDTH  alarm set threshold
- th_lo  input  WIDTH  alarm release threshold
- out_valid  output  1  one-cycle pulse when outputs reflect a new sample
- avg_out  output  WIDTH  window sum >> WIN_LOG2
- peak_out  output  WIDTH  max sample since reset/clear
- window_full  output  1  high once 8 samples have been accepted since reset/clear
- alarm  output  1  hysteresis alarm level
- alarm_count  output  8  alarm rising-edge count, saturating at 255

## Operation
- Storage: buffer of 8 × WIDTH, wr_ptr (3 bits, wraps 7→0), sum (WIDTH+WIN_LOG2 = 11 bits), fill count 0..8.
- Stage 1 runs at the accept edge, when in_valid=1 and clear=0:
  - sum ← sum − buf[wr_ptr] + in_mag
  - buf[wr_ptr] ← in_mag
  - wr_ptr ← wr_ptr+1
  - fill saturates at 8
  - The sample is also registered into the stage-2 pipe.
- Buffer entries reset to 0, so a partial window averages as if the missing samples are zeros. The sum never over- or underflows: max 8×255 = 2040.
- Stage 2 runs on the next edge:
  - avg_out ← sum[10:3] (truncate)
  - peak_out ← max(peak_out, sample)
  - window_full ← (fill==8)
  - out_valid ← 1 for exactly one cycle
- State machine, 2 states:
  - FILL (reset/clear state): alarm is held 0 and not evaluated.
  - FILL → RUN at the stage-2 update where fill reaches 8. Alarm evaluation starts on that same update.
  - RUN: if new avg ≥ th_hi, alarm ← 1. Otherwise, if new avg < th_lo, alarm ← 0. Otherwise alarm holds.
  - Set has priority when th_lo > th_hi.
  - A 0→1 alarm transition increments alarm_count, saturating at 255.
  - RUN → FILL only on clear or reset.
- clear:
  - Zeroes buf, sum, wr_ptr, fill, avg_out, peak_out, window_full, alarm and alarm_count, and returns the FSM to FILL.
  - Wins over a simultaneous in_valid; that sample is dropped.
  - Squashes any sample in flight in stage 2: no out_valid follows it.
- Thresholds are sampled at the stage-2 edge and may change at any time.

## Timing
- Reset (async assert, sync release via the flops) sets every output to 0: out_valid, avg_out, peak_out, window_full, alarm, alarm_count. FSM=FILL, buffer zeroed.
- Latency: in_valid high at edge k → outputs updated and out_valid=1 during cycle after edge k+1.
- Throughput: one sample per cycle. Back-to-back in_valid yields back-to-back out_valid pulses, each with the correct running sum; no bubbles.
- in_valid low: no state change; outputs hold; out_valid=0.
- Reset mid-operation: all state is discarded immediately. No out_valid is produced for samples accepted before the reset.
- Outputs are stable between out_valid pulses.

## Test plan
- Reset: assert rst mid-stream → all outputs 0 asynchronously. After release, the first sample 40 → out_valid 2 edges later, avg_out=5, peak_out=40, window_full=0.
- Window fill: feed 10,20,…,80 on consecutive cycles → 8 out_valid pulses. Final avg_out=45, peak_out=80, window_full=1, alarm=0 (th_hi=50, th_lo=30).
- Wrap and alarm set: feed 90 next → avg_out=55, alarm=1, alarm_count=1, peak_out=90.
- Hysteresis release: feed zeros → avg sequence 52,48,43,37,30,21. alarm stays 1 through 30 and drops at 21; alarm_count stays 1.
- Clear collision: clear=1 together with in_valid=1, in_mag=200 → no out_valid for it. All stats 0, FSM FILL, peak_out stays 0 on the following idle cycles.
- Saturation/gaps:
  - Toggle the alarm 260 times (th_hi=th_lo=100, alternate full windows of 255 and 0) → alarm_count=255.
  - Irregular in_valid gaps give results identical to the gapless stream.
